// File: rtl/corr_sample_feeder.sv
// corr_sample_feeder: buffers packed correlator samples and writes one per accelerator-ready
// handshake to the accelerator sample port, sequencing arm, integration and drain.
module corr_sample_feeder #(
  parameter logic [31:0] FIFO_BASE_ADDR = 32'h80000040,
  parameter int          INT_LENGTH     = 10,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        s_valid_i,
  input  logic [31:0] s_data_i,
  output logic        s_ready_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_ack_i,
  output logic        acc_on_o,
  input  logic        acc_ready_i,
  input  logic        calc_fin_i,
  output logic        busy_o,
  output logic        done_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(INT_LENGTH) + 1;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_RDY, WRITE, DRAIN, FIN} state_t;
  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] sample_cnt;
  logic          ready_en, rdy_flag, full, empty, push, pop;
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign empty     = count == '0;
  // ready_en keeps s_ready low through reset and the edge it is released on
  assign s_ready_o = ready_en & ~full;
  assign push      = s_valid_i & s_ready_o;
  assign pop       = (state == WRITE) & m_ack_i;
  assign m_req_o   = state == WRITE;
  assign m_we_o    = m_req_o;
  assign m_addr_o  = m_req_o ? FIFO_BASE_ADDR : '0;
  assign m_wdata_o = m_req_o ? mem[rd_ptr] : '0;
  assign acc_on_o  = state != IDLE;
  assign busy_o    = state != IDLE;
  assign done_o    = state == FIN;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data_i;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rdy_flag   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      // a ready pulse coinciding with a completed write keeps the flag set
      rdy_flag <= (state == ARM || (acc_ready_i && busy_o)) ? 1'b1 : pop ? 1'b0 : rdy_flag;
      case (state)
        IDLE:     if (start_i) state <= ARM;
        ARM: begin
          sample_cnt <= '0;
          state      <= WAIT_RDY;
        end
        WAIT_RDY: if (rdy_flag && !empty) state <= WRITE;
        WRITE: if (m_ack_i) begin
          sample_cnt <= sample_cnt + CW'(1);
          state      <= (sample_cnt + CW'(1) == CW'(INT_LENGTH)) ? DRAIN : WAIT_RDY;
        end
        DRAIN:    if (calc_fin_i) state <= FIN;
        FIN: begin
          sample_cnt <= '0;
          state      <= IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_corr_sample_feeder.sv
// tb_corr_sample_feeder: directed runs checked every cycle against a queue-based model
// of the feeder, plus hand-computed literal expectations.
module tb_corr_sample_feeder;
  localparam logic [31:0] BASE  = 32'h80000040;
  localparam int          LEN   = 10;
  localparam int          DEPTH = 4;
  logic        clk = 0, rst = 1, start_i = 0, s_valid_i = 0, m_ack_i = 0, calc_fin_i = 0;
  logic        rdy_auto = 0, rdy_man = 0, auto_rdy = 0;
  logic [31:0] s_data_i = 0;
  logic        s_ready_o, m_req_o, m_we_o, acc_on_o, busy_o, done_o;
  logic [31:0] m_addr_o, m_wdata_o;
  wire         acc_ready_i = rdy_auto | rdy_man;
  int vecs = 0, errs = 0, cyc = 0;
  logic [31:0] log_d[$];
  logic [31:0] log_a[$];
  int          log_t[$];
  logic [31:0] q[$];
  bit m_ready_en, m_run, m_arm, m_pend, m_drain, m_fin, m_rdy;
  int m_wr;

  always #5 clk = ~clk;

  corr_sample_feeder #(.FIFO_BASE_ADDR(BASE), .INT_LENGTH(LEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .s_valid_i(s_valid_i), .s_data_i(s_data_i),
    .s_ready_o(s_ready_o), .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_ack_i(m_ack_i), .acc_on_o(acc_on_o), .acc_ready_i(acc_ready_i),
    .calc_fin_i(calc_fin_i), .busy_o(busy_o), .done_o(done_o));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model: one step per clock using the run rules directly on a sample queue
  task automatic model_step();
    bit push, set_r, done_w;
    int sz;
    if (!rst) begin
      q.delete();
      {m_ready_en, m_run, m_arm, m_pend, m_drain, m_fin, m_rdy} = '0;
      m_wr = 0;
      return;
    end
    push   = s_valid_i && m_ready_en && q.size() < DEPTH;
    set_r  = m_arm || (acc_ready_i && m_run);
    done_w = m_pend && m_ack_i;
    sz     = q.size();
    if (m_fin) begin
      m_fin = 0; m_run = 0;
    end else if (!m_run) begin
      if (start_i) begin m_run = 1; m_arm = 1; m_wr = 0; end
    end else if (m_arm) m_arm = 0;
    else if (m_pend) begin
      if (m_ack_i) begin
        m_pend = 0;
        void'(q.pop_front());
        m_wr++;
        if (m_wr == LEN) m_drain = 1;
      end
    end else if (m_drain) begin
      if (calc_fin_i) begin m_drain = 0; m_fin = 1; end
    end else if (m_rdy && sz > 0) m_pend = 1;
    m_rdy = set_r ? 1'b1 : done_w ? 1'b0 : m_rdy;
    if (push) q.push_back(s_data_i);
    m_ready_en = 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    chk("m_req", m_req_o, m_pend);
    chk("m_we", m_we_o, m_pend);
    chk("m_addr", m_addr_o, m_pend ? BASE : 32'h0);
    chk("m_wdata", m_wdata_o, (m_pend && q.size() > 0) ? q[0] : 32'h0);
    chk("acc_on", acc_on_o, m_run);
    chk("busy", busy_o, m_run);
    chk("done", done_o, m_fin);
    chk("s_ready", s_ready_o, m_ready_en && q.size() < DEPTH);
    if (rst && m_req_o && m_ack_i) begin
      log_d.push_back(m_wdata_o);
      log_a.push_back(m_addr_o);
      log_t.push_back(cyc);
    end
  end

  initial forever begin
    @(negedge clk);
    if (auto_rdy && m_req_o && m_ack_i) begin
      repeat (3) @(negedge clk);
      rdy_auto = 1;
      @(negedge clk);
      rdy_auto = 0;
    end
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d);
    bit acc = 0;
    s_valid_i = 1;
    s_data_i  = d;
    for (int i = 0; i < 300; i++) begin
      acc = s_ready_o;
      @(negedge clk);
      if (acc) break;
    end
    s_valid_i = 0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    start_i = 1;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_req(input int lim);
    for (int i = 0; i < lim && !m_req_o; i++) @(negedge clk);
    chk("req_seen", m_req_o, 1);
  endtask

  task automatic wait_log(input int n, input int lim);
    for (int i = 0; i < lim && log_d.size() < n; i++) @(negedge clk);
    chk("log_count", log_d.size(), n);
  endtask

  task automatic finish_run();
    tick(2);
    chk("drain_busy", busy_o, 1);
    chk("drain_req", m_req_o, 0);
    calc_fin_i = 1;
    @(negedge clk);
    calc_fin_i = 0;
    chk("done_pulse", done_o, 1);
    @(negedge clk);
    chk("done_drop", done_o, 0);
    chk("busy_drop", busy_o, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, m_req_o, 0);
    chk({tag, "_we"}, m_we_o, 0);
    chk({tag, "_addr"}, m_addr_o, 0);
    chk({tag, "_wdata"}, m_wdata_o, 0);
    chk({tag, "_acc_on"}, acc_on_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_s_ready"}, s_ready_o, 0);
  endtask

  initial begin
    logic [31:0] e, a0, d0;
    int base;
    #1 rst = 0;
    #2 chk_reset_outs("rst0");
    tick(2);
    chk("ready_in_reset", s_ready_o, 0);
    rst = 1;
    @(negedge clk);
    chk("ready_after_reset", s_ready_o, 1);

    // ten-sample run through a four-entry buffer
    for (int k = 0; k < 4; k++) push(32'h04030201 + k);
    chk("full_after_4", s_ready_o, 0);
    m_ack_i  = 1;
    auto_rdy = 1;
    fork
      for (int k = 4; k < 10; k++) push(32'h04030201 + k);
      pulse_start();
    join
    wait_log(10, 400);
    finish_run();
    for (int k = 0; k < 10; k++) begin
      e = 32'h04030201 + k;
      chk("run1_data", log_d[k], e);
      chk("run1_addr", log_a[k], 32'h80000040);
      if (k > 0) chk("run1_gap", (log_t[k] - log_t[k-1]) >= 2, 1);
    end
    auto_rdy = 0;
    m_ack_i  = 0;
    tick(6);

    // write held without acknowledge for five cycles
    push(32'hA0A0A0A0);
    pulse_start();
    wait_req(20);
    a0 = m_addr_o;
    d0 = m_wdata_o;
    chk("hold_addr0", a0, 32'h80000040);
    chk("hold_data0", d0, 32'hA0A0A0A0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_req", m_req_o, 1);
      chk("hold_addr", m_addr_o, a0);
      chk("hold_data", m_wdata_o, d0);
    end
    m_ack_i = 1;
    @(negedge clk);
    m_ack_i = 0;
    chk("hold_req_drop", m_req_o, 0);
    chk("hold_one_pop", log_d.size(), 11);
    chk("hold_empty", s_ready_o, 1);

    // start and calc_fin while waiting must be ignored; ready arrives with empty buffer
    rdy_man = 1; start_i = 1; calc_fin_i = 1;
    @(negedge clk);
    rdy_man = 0; start_i = 0; calc_fin_i = 0;
    tick(2);
    chk("empty_no_req", m_req_o, 0);
    push(32'hB0B0B0B0);
    chk("push_cyc1_req", m_req_o, 0);
    @(negedge clk);
    chk("push_cyc2_req", m_req_o, 1);
    chk("push_cyc2_data", m_wdata_o, 32'hB0B0B0B0);
    m_ack_i = 1; rdy_man = 1;
    @(negedge clk);
    m_ack_i = 0; rdy_man = 0;
    chk("coinc_req_drop", m_req_o, 0);
    push(32'hC0C0C0C0);
    chk("rdy_kept_cyc1", m_req_o, 0);
    @(negedge clk);
    chk("rdy_kept_req", m_req_o, 1);
    m_ack_i = 1;
    @(negedge clk);
    m_ack_i = 0;
    chk("three_writes", log_d.size(), 13);

    // reset while a fourth write is pending
    rdy_man = 1;
    @(negedge clk);
    rdy_man = 0;
    push(32'hD0D0D0D0);
    @(negedge clk);
    chk("pre_rst_req", m_req_o, 1);
    #1 rst = 0;
    #1 chk_reset_outs("async_rst");
    tick(2);
    rst = 1;
    @(negedge clk);
    chk("post_rst_ready", s_ready_o, 1);
    chk("post_rst_busy", busy_o, 0);

    // full run after reset; the lost sample must not reappear
    base     = log_d.size();
    m_ack_i  = 1;
    auto_rdy = 1;
    fork
      for (int k = 0; k < 10; k++) push(32'h11000000 + k);
      pulse_start();
    join
    wait_log(base + 10, 400);
    finish_run();
    for (int k = 0; k < 10; k++) begin
      e = 32'h11000000 + k;
      chk("run2_data", log_d[base + k], e);
    end
    auto_rdy = 0;
    m_ack_i  = 0;
    tick(6);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
